apb_uart: RTL and testbench

- APB slave UART sitting directly downstream of the APB bus decoder, in slave slot 1 (address window `paddr[31:24] == 8'hF1`).
- Converts zero-wait APB register accesses into 8N1 serial traffic.
  - TX side: parameterised TX FIFO.
  - RX side: single-byte receive holding register.
- Drives one level interrupt toward the interrupt controller.

---
 rtl/apb_uart_if.sv | 21 ++
 rtl/apb_uart.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_apb_uart.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_if.sv
// APB slave-side bus bundle for apb_uart; the master modport drives requests, the slave answers.
interface apb_uart_if;
    logic [31:0] paddr;
    logic        pwrite;
    logic        psel;
    logic        penable;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_uart.sv
// Zero-wait APB UART: TX FIFO feeding an 8N1 transmitter, optional receiver with a one-byte
// holding register. Define APB_UART_RX_EN to build the receiver.
module apb_uart #(
    parameter int unsigned TX_FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET     = 16'd433
) (
    input  logic       clk,
    input  logic       reset,
    apb_uart_if.slave  io_apb,
    output logic       io_txd,
    input  logic       io_rxd,
    output logic       io_irq
);

    localparam int unsigned AW = $clog2(TX_FIFO_DEPTH);
`ifdef APB_UART_RX_EN
    localparam logic [3:0] CtrlMask = 4'b1111;
`else
    localparam logic [3:0] CtrlMask = 4'b1001;
`endif

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    // Bus decode
    logic       access;
    logic [1:0] addr;
    logic       wr_data, wr_status, wr_ctrl, wr_div, rd_data;

    assign access    = io_apb.psel & io_apb.penable;
    assign addr      = io_apb.paddr[3:2];
    assign wr_data   = access & io_apb.pwrite & (addr == 2'd0);
    assign wr_status = access & io_apb.pwrite & (addr == 2'd1);
    assign wr_ctrl   = access & io_apb.pwrite & (addr == 2'd2);
    assign wr_div    = access & io_apb.pwrite & (addr == 2'd3);
    assign rd_data   = access & ~io_apb.pwrite & (addr == 2'd0);

    logic [3:0]  ctrl_q;
    logic [15:0] div_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q <= 4'd0;
            div_q  <= DIV_RESET;
        end else begin
            if (wr_ctrl) ctrl_q <= io_apb.pwdata[3:0] & CtrlMask;
            if (wr_div)  div_q  <= io_apb.pwdata[15:0];
        end
    end

    logic tx_en, rx_en, rx_irq_en, tx_irq_en;
    assign tx_en     = ctrl_q[0];
    assign rx_en     = ctrl_q[1];
    assign rx_irq_en = ctrl_q[2];
    assign tx_irq_en = ctrl_q[3];

    // TX FIFO
    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, rd_ptr_q;
    logic        tx_full, tx_empty, tx_push, tx_pop;
    logic [7:0]  fifo_head;

    assign tx_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign tx_empty  = (wr_ptr_q == rd_ptr_q);
    assign tx_push   = wr_data & ~tx_full;
    assign fifo_head = fifo_mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (tx_push) fifo_mem[wr_ptr_q[AW-1:0]] <= io_apb.pwdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (tx_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (tx_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // TX FSM
    tx_state_e   tx_state_q, tx_state_d;
    logic [15:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        tx_tick, tx_busy;

    assign tx_tick = (tx_cnt_q == 16'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= 16'd0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'd0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        unique case (tx_state_q)
            TxIdle: begin
                if (tx_pop) begin
                    tx_state_d = TxStart;
                    tx_cnt_d   = div_q;
                    tx_shift_d = fifo_head;
                end
            end
            TxStart: begin
                if (tx_tick) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = div_q;
                    tx_bit_d   = 3'd0;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TxData: begin
                if (tx_tick) begin
                    tx_cnt_d   = div_q;
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == 3'd7) tx_state_d = TxStop;
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            TxStop: begin
                if (tx_tick) begin
                    // Chain straight into the next start bit so frames run back to back
                    if (tx_pop) begin
                        tx_state_d = TxStart;
                        tx_cnt_d   = div_q;
                        tx_shift_d = fifo_head;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 16'd1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        io_txd  = 1'b1;
        tx_busy = (tx_state_q != TxIdle);
        tx_pop  = 1'b0;
        unique case (tx_state_q)
            TxIdle:  tx_pop = tx_en & ~tx_empty;
            TxStart: io_txd = 1'b0;
            TxData:  io_txd = tx_shift_q[0];
            TxStop:  tx_pop = tx_tick & tx_en & ~tx_empty;
            default: io_txd = 1'b1;
        endcase
    end

    // Receiver
    logic       rx_valid_q, rx_overrun_q, frame_err_q;
    logic [7:0] rx_byte_q;

`ifdef APB_UART_RX_EN
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic        rx_meta_q, rx_sync_q, rx_prev_q;
    rx_state_e   rx_state_q, rx_state_d;
    logic [15:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [16:0] rx_half;
    logic        rx_sample, rx_stop_ok, rx_stop_bad, rx_done_q;
    logic        unused_bits;

    assign rx_half   = ({1'b0, div_q} + 17'd1) >> 1;
    assign rx_sample = (rx_cnt_q == div_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q   <= 16'd0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'd0;
            rx_done_q  <= 1'b0;
        end else begin
            rx_meta_q  <= io_rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_done_q  <= rx_stop_ok;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + 16'd1;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        unique case (rx_state_q)
            RxIdle: begin
                rx_cnt_d = 16'd0;
                if (rx_en && rx_prev_q && !rx_sync_q) rx_state_d = RxStart;
            end
            RxStart: begin
                if (rx_cnt_q == rx_half[15:0]) begin
                    rx_cnt_d   = 16'd0;
                    rx_bit_d   = 3'd0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end
            end
            RxData: begin
                if (rx_sample) begin
                    rx_cnt_d   = 16'd0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RxStop;
                end
            end
            RxStop: begin
                if (rx_sample) rx_state_d = RxIdle;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_comb begin
        rx_stop_ok  = 1'b0;
        rx_stop_bad = 1'b0;
        if (rx_state_q == RxStop && rx_sample) begin
            rx_stop_ok  = rx_sync_q;
            rx_stop_bad = ~rx_sync_q;
        end
    end

    // A load coinciding with a DATA read replaces the byte being read instead of overrunning
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_byte_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            rx_overrun_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            if (rx_done_q && (!rx_valid_q || rd_data)) begin
                rx_byte_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
            end else if (rd_data) begin
                rx_valid_q <= 1'b0;
            end
            if (rx_done_q && rx_valid_q && !rd_data) rx_overrun_q <= 1'b1;
            else if (wr_status && io_apb.pwdata[3])  rx_overrun_q <= 1'b0;
            if (rx_stop_bad)                         frame_err_q  <= 1'b1;
            else if (wr_status && io_apb.pwdata[5])  frame_err_q  <= 1'b0;
        end
    end

    assign unused_bits = ^{io_apb.paddr[31:4], io_apb.paddr[1:0], io_apb.pwdata[31:16],
                           rx_half[16]};
`else
    logic unused_bits;

    assign rx_byte_q    = 8'd0;
    assign rx_valid_q   = 1'b0;
    assign rx_overrun_q = 1'b0;
    assign frame_err_q  = 1'b0;
    assign unused_bits  = ^{io_apb.paddr[31:4], io_apb.paddr[1:0], io_apb.pwdata[31:16],
                            io_rxd, rx_en, wr_status, rd_data};
`endif

    // Bus responses
    logic [31:0] status;
    assign status = {26'd0, frame_err_q, tx_busy, rx_overrun_q, rx_valid_q, tx_empty, tx_full};

    always_comb begin
        io_apb.prdata = 32'd0;
        if (io_apb.psel && !io_apb.pwrite) begin
            unique case (addr)
                2'd0: io_apb.prdata = rx_valid_q ? {24'd0, rx_byte_q} : 32'd0;
                2'd1: io_apb.prdata = status;
                2'd2: io_apb.prdata = {28'd0, ctrl_q};
                2'd3: io_apb.prdata = {16'd0, div_q};
                default: io_apb.prdata = 32'd0;
            endcase
        end
    end

    assign io_apb.pready  = 1'b1;
    assign io_apb.pslverr = access & (addr == 2'd0) & (io_apb.pwrite ? tx_full : ~rx_valid_q);

    logic irq_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= (rx_irq_en & rx_valid_q) | (tx_irq_en & tx_empty & ~tx_busy);
    end
    assign io_irq = irq_q;

endmodule

// File: tb/tb_apb_uart.sv
// Directed bench for apb_uart: register reset values, TX framing, FIFO full, errors, reset
// mid-frame, and (with APB_UART_RX_EN) receive, overrun, framing and glitch rejection.
module tb_apb_uart;

    localparam logic [31:0] AData   = 32'hF100_0000;
    localparam logic [31:0] AStatus = 32'hF100_0004;
    localparam logic [31:0] ACtrl   = 32'hF100_0008;
    localparam logic [31:0] ADiv    = 32'hF100_000C;

    logic clk = 1'b0;
    logic reset;
    logic io_txd, io_rxd, io_irq;
    int   checks = 0;
    int   errors = 0;

    apb_uart_if bus ();

    apb_uart #(.TX_FIFO_DEPTH(4), .DIV_RESET(16'd433)) dut (
        .clk    (clk),
        .reset  (reset),
        .io_apb (bus),
        .io_txd (io_txd),
        .io_rxd (io_rxd),
        .io_irq (io_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(negedge clk);
        bus.paddr = a; bus.pwdata = d; bus.pwrite = 1'b1; bus.psel = 1'b1; bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        #1 err = bus.pslverr;
        @(posedge clk);
        #1 bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic err);
        @(negedge clk);
        bus.paddr = a; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
        @(negedge clk);
        bus.penable = 1'b1;
        #1 d = bus.prdata; err = bus.pslverr;
        @(posedge clk);
        #1 bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    // One 8N1 frame on rxd with 8 clocks per bit
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            io_rxd = frame[i];
            repeat (7) @(negedge clk);
        end
        io_rxd = 1'b1;
    endtask

    logic [31:0] rd;
    logic        err;
    logic [9:0]  frame;
    logic [7:0]  b;

    initial begin
        reset = 1'b1;
        io_rxd = 1'b1;
        bus.paddr = 32'd0; bus.pwdata = 32'd0; bus.pwrite = 1'b0;
        bus.psel = 1'b0; bus.penable = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_txd", {31'd0, io_txd}, 32'd1);
        check("rst_irq", {31'd0, io_irq}, 32'd0);
        check("rst_pready", {31'd0, bus.pready}, 32'd1);
        check("rst_prdata", bus.prdata, 32'd0);
        check("rst_pslverr", {31'd0, bus.pslverr}, 32'd0);
        @(negedge clk) reset = 1'b0;
        apb_read(AStatus, rd, err);
        check("rst_status", rd, 32'h02);
        apb_read(ADiv, rd, err);
        check("rst_div", rd, 32'h1B1);
        apb_read(ACtrl, rd, err);
        check("rst_ctrl", rd, 32'h0);

        // TX interrupt when FIFO empty and transmitter idle
        apb_write(ACtrl, 32'h8, err);
        check("irq_lag", {31'd0, io_irq}, 32'd0);
        repeat (2) @(negedge clk);
        check("irq_tx", {31'd0, io_irq}, 32'd1);
        apb_write(ACtrl, 32'hF, err);
        apb_read(ACtrl, rd, err);
`ifdef APB_UART_RX_EN
        check("ctrl_rb", rd, 32'hF);
`else
        check("ctrl_rb", rd, 32'h9);
`endif
        apb_write(ACtrl, 32'h0, err);
        repeat (2) @(negedge clk);
        check("irq_off", {31'd0, io_irq}, 32'd0);

        // Single frame 0xA5
        apb_write(ADiv, 32'd3, err);
        apb_write(ACtrl, 32'h1, err);
        apb_write(AData, 32'hA5, err);
        check("tx_push_err", {31'd0, err}, 32'd0);
        check("tx_idle_at_t", {31'd0, io_txd}, 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("tx_a5_bit%0d", k), {31'd0, io_txd}, {31'd0, frame[k]});
            repeat (3) @(negedge clk);
        end
        apb_read(AStatus, rd, err);
        check("tx_status_after", rd, 32'h02);

        // FIFO full, then four back-to-back frames
        apb_write(ACtrl, 32'h0, err);
        for (int i = 1; i <= 4; i++) begin
            apb_write(AData, i, err);
            check($sformatf("fifo_push%0d_err", i), {31'd0, err}, 32'd0);
        end
        apb_write(AData, 32'h05, err);
        check("fifo_push5_err", {31'd0, err}, 32'd1);
        apb_read(AStatus, rd, err);
        check("fifo_status_full", rd, 32'h01);
        apb_write(ACtrl, 32'h1, err);
        @(posedge clk);
        for (int f = 0; f < 4; f++) begin
            b = 8'(f + 1);
            frame = {1'b1, b, 1'b0};
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                check($sformatf("b2b_f%0d_bit%0d", f, k), {31'd0, io_txd}, {31'd0, frame[k]});
                repeat (3) @(negedge clk);
            end
        end
        check("b2b_done_txd", {31'd0, io_txd}, 32'd1);
        apb_read(AStatus, rd, err);
        check("b2b_status", rd, 32'h02);

        // DATA read with nothing received
        apb_read(AData, rd, err);
        check("rd_empty_err", {31'd0, err}, 32'd1);
        check("rd_empty_data", rd, 32'd0);

        // Reset in the middle of a frame discards the queue
        apb_write(ACtrl, 32'h0, err);
        repeat (3) apb_write(AData, 32'h00, err);
        apb_write(ACtrl, 32'h1, err);
        repeat (6) @(negedge clk);
        check("mid_txd_low", {31'd0, io_txd}, 32'd0);
        reset = 1'b1;
        #1 check("mid_rst_txd", {31'd0, io_txd}, 32'd1);
        @(negedge clk) reset = 1'b0;
        apb_read(AStatus, rd, err);
        check("mid_rst_status", rd, 32'h02);
        apb_read(ADiv, rd, err);
        check("mid_rst_div", rd, 32'h1B1);

`ifdef APB_UART_RX_EN
        apb_write(ADiv, 32'd7, err);
        apb_write(ACtrl, 32'h6, err);
        send_rx(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        check("rx_irq", {31'd0, io_irq}, 32'd1);
        apb_read(AData, rd, err);
        check("rx_data", rd, 32'h3C);
        check("rx_data_err", {31'd0, err}, 32'd0);
        repeat (2) @(negedge clk);
        check("rx_irq_drop", {31'd0, io_irq}, 32'd0);

        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        apb_read(AStatus, rd, err);
        check("ovr_status", rd, 32'h0E);
        apb_read(AData, rd, err);
        check("ovr_data", rd, 32'h11);
        apb_read(AStatus, rd, err);
        check("ovr_status2", rd, 32'h0A);
        apb_write(AStatus, 32'h08, err);
        apb_read(AStatus, rd, err);
        check("ovr_clear", rd, 32'h02);

        send_rx(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        apb_read(AStatus, rd, err);
        check("ferr_status", rd, 32'h22);
        apb_write(AStatus, 32'h20, err);
        apb_read(AStatus, rd, err);
        check("ferr_clear", rd, 32'h02);

        @(negedge clk) io_rxd = 1'b0;
        repeat (2) @(negedge clk);
        io_rxd = 1'b1;
        repeat (100) @(negedge clk);
        apb_read(AStatus, rd, err);
        check("glitch_status", rd, 32'h02);
`else
        apb_write(ADiv, 32'd7, err);
        apb_write(ACtrl, 32'h6, err);
        send_rx(8'h3C, 1'b1);
        repeat (10) @(negedge clk);
        apb_read(AStatus, rd, err);
        check("norx_status", rd, 32'h02);
        apb_read(AData, rd, err);
        check("norx_data", rd, 32'd0);
        check("norx_err", {31'd0, err}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
